sequential_16bit_chk: RTL

Receive-side checker for the 16-bit free-running counter pattern that fabric user designs drive onto the IO bus. Samples a 16-bit bus of unknown clock relationship, debounces it, and verifies that every accepted value is the previous one plus one (mod 2^16). Counts good steps and errors, and flags restarts and stalls. Sits on the fabric side opposite a counter design as a loop-back self-test.

---
 rtl/sequential_16bit_chk_pkg.sv | 14 +
 rtl/sequential_16bit_chk_stable_filter.sv | 52 +++++
 rtl/sequential_16bit_chk.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sequential_16bit_chk_pkg.sv
// Shared types and constants for the
// 16-bit counter-pattern loop-back checker.
package sequential_16bit_chk_pkg;

   localparam int DW = 16;

   localparam logic [7:0] ERR_MAX = 8'hFF;

   typedef enum logic {
      ACQ,
      TRACK
   } state_t;

endpackage

// File: rtl/sequential_16bit_chk_stable_filter.sv
// Synchronizes an async bus and issues one accept
// strobe per value held stable long enough.
module stable_filter
   import sequential_16bit_chk_pkg::*;
#(
   parameter int W             = DW,
   parameter int STABLE_CYCLES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] i_d,
   output logic         o_acc,
   output logic [W-1:0] o_val
);

   localparam int SW = $clog2(STABLE_CYCLES);
   localparam logic [SW-1:0] LAST = SW'(STABLE_CYCLES - 1);
   localparam logic [SW-1:0] PRE  = SW'(STABLE_CYCLES - 2);

   logic [W-1:0]  r_s1;
   logic [W-1:0]  r_s2;
   logic [W-1:0]  r_cand;
   logic [SW-1:0] r_stab;
   logic          r_acc;

   // Sync chain, candidate tracking, and a single strobe
   // when the stability count first hits its top value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_cand <= '0;
         r_stab <= '0;
         r_acc  <= 1'b0;
      end else begin
         r_s1  <= i_d;
         r_s2  <= r_s1;
         r_acc <= 1'b0;
         if (r_s2 != r_cand) begin
            r_cand <= r_s2;
            r_stab <= '0;
         end else if (r_stab != LAST) begin
            r_stab <= r_stab + 1'b1;
            r_acc  <= (r_stab == PRE);
         end
      end
   end

   assign o_acc = r_acc;
   assign o_val = r_cand;

endmodule

// File: rtl/sequential_16bit_chk.sv
// Checks that accepted bus values step by +1,
// counting steps/errors and flagging restarts and stalls.
module sequential_16bit_chk
   import sequential_16bit_chk_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int STALL_CYCLES  = 4096
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] cnt_i,
   output logic          locked,
   output logic [DW-1:0] last_val,
   output logic          step_p,
   output logic          restart_p,
   output logic          err_p,
   output logic [DW-1:0] good_cnt,
   output logic [7:0]    err_cnt,
   output logic          stalled
);

   localparam int SCW = $clog2(STALL_CYCLES);
   localparam logic [SCW-1:0] STALL_MAX = SCW'(STALL_CYCLES - 1);
   localparam logic [SCW-1:0] STALL_PRE = SCW'(STALL_CYCLES - 2);

   logic          w_acc;
   logic [DW-1:0] w_val;
   logic [DW-1:0] w_inc;
   logic          w_is_step;
   logic          w_is_zero;

   state_t        r_state;
   logic          r_locked;
   logic [DW-1:0] r_last;
   logic          r_step;
   logic          r_restart;
   logic          r_err;
   logic [DW-1:0] r_good;
   logic [7:0]    r_errc;
   logic [SCW-1:0] r_stall_cnt;
   logic          r_stalled;

   stable_filter #(
      .W             (DW),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_filt (
      .clk   (clk),
      .rst   (rst),
      .i_d   (cnt_i),
      .o_acc (w_acc),
      .o_val (w_val)
   );

   assign w_inc     = r_last + 16'd1;
   assign w_is_step = (w_val == w_inc);
   assign w_is_zero = (w_val == '0);

   // Acquire/track FSM with classification, counters
   // and stall detection; all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ACQ;
         r_locked    <= 1'b0;
         r_last      <= '0;
         r_step      <= 1'b0;
         r_restart   <= 1'b0;
         r_err       <= 1'b0;
         r_good      <= '0;
         r_errc      <= '0;
         r_stall_cnt <= '0;
         r_stalled   <= 1'b0;
      end else begin
         r_step    <= 1'b0;
         r_restart <= 1'b0;
         r_err     <= 1'b0;
         case (r_state)
            ACQ: begin
               r_stall_cnt <= '0;
               r_stalled   <= 1'b0;
               if (w_acc) begin
                  r_last   <= w_val;
                  r_locked <= 1'b1;
                  r_state  <= TRACK;
               end
            end
            TRACK: begin
               if (w_acc) begin
                  r_stall_cnt <= '0;
                  r_stalled   <= 1'b0;
                  if (w_val != r_last) begin
                     r_last <= w_val;
                     if (w_is_step) begin
                        r_step <= 1'b1;
                        r_good <= r_good + 16'd1;
                     end else if (w_is_zero) begin
                        r_restart <= 1'b1;
                     end else begin
                        r_err <= 1'b1;
                        if (r_errc != ERR_MAX)
                           r_errc <= r_errc + 8'd1;
                     end
                  end
               end else begin
                  if (r_stall_cnt != STALL_MAX)
                     r_stall_cnt <= r_stall_cnt + 1'b1;
                  if (r_stall_cnt >= STALL_PRE)
                     r_stalled <= 1'b1;
               end
            end
            default: r_state <= ACQ;
         endcase
      end
   end

   assign locked    = r_locked;
   assign last_val  = r_last;
   assign step_p    = r_step;
   assign restart_p = r_restart;
   assign err_p     = r_err;
   assign good_cnt  = r_good;
   assign err_cnt   = r_errc;
   assign stalled   = r_stalled;

endmodule
